// File: rtl/uart_pkg.sv
// Shared definitions for the UART CPU-side register controller: register map,
// STATUS/CTRL bit positions and bus FSM state encodings.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam int STAT_TX_NOT_FULL  = 0;
  localparam int STAT_RX_NOT_EMPTY = 1;
  localparam int STAT_TX_OVR       = 2;
  localparam int STAT_RX_OVR       = 3;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_FLUSH     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } bus_state_t;

  function automatic logic [7:0] status_byte(input logic rx_ovr, input logic tx_ovr,
                                             input logic rx_empty, input logic tx_full);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_TX_NOT_FULL]  = ~tx_full;
    s[STAT_RX_NOT_EMPTY] = ~rx_empty;
    s[STAT_TX_OVR]       = tx_ovr;
    s[STAT_RX_OVR]       = rx_ovr;
    return s;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Plain flop-chain synchronizer for the asynchronous CPU bus inputs.
module bus_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Deliberately not reset: the synced bus level must survive a controller reset
  // so a bus cycle still in progress is not mistaken for a fresh one.
  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    chain[0] <= d;
    for (int i = 1; i < STAGES; i++) begin
      chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_bus_ctrl.sv
// CPU-side register controller for the UART: decodes the async 6502-style bus and
// sequences TX pushes / RX pop windows, plus STATUS, CTRL, SCRATCH and overrun flags.
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2,
  input  logic       ncs,
  input  logic       nwe,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tx_write_trig,
  input  logic       tx_full,
  input  logic       tx_empty,
  output logic       rx_read_active,
  input  logic [7:0] rx_out,
  input  logic       rx_full,
  input  logic       rx_empty,
  input  logic       rx_write_trig,
  output logic       fifo_reset,
  output logic       irq_n
);

  logic       s_phi2;
  logic       s_ncs;
  logic       s_nwe;
  logic [1:0] s_addr;

  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_phi2 (.clk(clk), .d(phi2), .q(s_phi2));
  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .d(ncs),  .q(s_ncs));
  bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_nwe  (.clk(clk), .d(nwe),  .q(s_nwe));
  bus_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_addr (.clk(clk), .d(addr), .q(s_addr));

  bus_state_t state;
  logic [1:0] acc_addr;
  logic [6:0] ctrl;
  logic [7:0] scratch;
  logic       tx_ovr;
  logic       rx_ovr;
  logic       armed;
  logic       rd_empty;

  logic       access;
  logic       bus_gone;
  logic       clr_ovr;
  logic [7:0] status;
  logic [7:0] entry_rdata;
  logic [7:0] held_rdata;

  // armed stays low after reset until phi2 is seen low, so a bus cycle that was
  // cut by reset is not decoded a second time.
  assign access   = armed && !s_ncs && s_phi2;
  assign bus_gone = !s_phi2 || s_ncs;
  assign clr_ovr  = (state == ST_READ) && bus_gone && (acc_addr == ADDR_STATUS);
  assign status   = status_byte(rx_ovr, tx_ovr, rx_empty, tx_full);

  function automatic logic [7:0] reg_value(input logic [1:0] a, input logic [7:0] st,
                                           input logic [6:0] c, input logic [7:0] sc);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      ADDR_STATUS:  v = st;
      ADDR_CTRL:    v = {1'b0, c};
      ADDR_SCRATCH: v = sc;
      default:      v = 8'h00;
    endcase
    return v;
  endfunction

  assign entry_rdata = reg_value(s_addr, status, ctrl, scratch);
  assign held_rdata  = reg_value(acc_addr, status, ctrl, scratch);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      acc_addr       <= ADDR_DATA;
      ctrl           <= 7'h00;
      scratch        <= 8'h00;
      tx_ovr         <= 1'b0;
      rx_ovr         <= 1'b0;
      armed          <= 1'b0;
      rd_empty       <= 1'b0;
      data_out       <= 8'h00;
      data_oe        <= 1'b0;
      tx_write_trig  <= 1'b0;
      rx_read_active <= 1'b0;
      fifo_reset     <= 1'b0;
      irq_n          <= 1'b1;
    end else begin
      tx_write_trig <= 1'b0;
      fifo_reset    <= 1'b0;
      if (!s_phi2) armed <= 1'b1;

      tx_ovr <= (tx_write_trig && tx_full) || (tx_ovr && !clr_ovr);
      rx_ovr <= (rx_write_trig && rx_full) || (rx_ovr && !clr_ovr);
      irq_n  <= !((ctrl[CTRL_RX_IRQ_EN] && !rx_empty) ||
                  (ctrl[CTRL_TX_IRQ_EN] && tx_empty) || rx_ovr || tx_ovr);

      case (state)
        ST_IDLE: begin
          if (access) begin
            acc_addr <= s_addr;
            if (!s_nwe) begin
              state <= ST_WRITE;
              case (s_addr)
                ADDR_DATA: tx_write_trig <= 1'b1;
                ADDR_CTRL: begin
                  ctrl       <= data_in[6:0];
                  fifo_reset <= data_in[CTRL_FLUSH];
                end
                ADDR_SCRATCH: scratch <= data_in;
                default: ;
              endcase
            end else begin
              state          <= ST_READ;
              data_oe        <= 1'b1;
              rd_empty       <= rx_empty;
              rx_read_active <= (s_addr == ADDR_DATA);
              data_out       <= (s_addr == ADDR_DATA) ? 8'h00 : entry_rdata;
            end
          end
        end
        ST_WRITE: state <= ST_HOLD;
        ST_READ: begin
          if (bus_gone) begin
            state          <= ST_IDLE;
            data_oe        <= 1'b0;
            rx_read_active <= 1'b0;
            data_out       <= 8'h00;
          end else if (acc_addr == ADDR_DATA) begin
            data_out <= rd_empty ? 8'h00 : rx_out;
          end else begin
            data_out <= held_rdata;
          end
        end
        ST_HOLD: if (bus_gone) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: drives 6502-style bus cycles against modelled FIFO flags.
module tb_uart_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       phi2;
  logic       ncs;
  logic       nwe;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       tx_write_trig;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_read_active;
  logic [7:0] rx_out;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_write_trig;
  logic       fifo_reset;
  logic       irq_n;

  uart_bus_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .phi2(phi2), .ncs(ncs), .nwe(nwe), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .tx_write_trig(tx_write_trig), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_read_active(rx_read_active), .rx_out(rx_out), .rx_full(rx_full),
    .rx_empty(rx_empty), .rx_write_trig(rx_write_trig),
    .fifo_reset(fifo_reset), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  // Output monitors, sampled on the falling edge.
  int         trig_cnt = 0;
  int         rra_rise = 0;
  int         flush_cnt = 0;
  logic [7:0] trig_data = 8'h00;
  logic       rra_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_write_trig) begin
      trig_cnt++;
      trig_data = data_in;
    end
    if (rx_read_active && !rra_prev) rra_rise++;
    rra_prev = rx_read_active;
    if (fifo_reset) flush_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; nwe = 1'b0; data_in = d; ncs = 1'b0; phi2 = 1'b1;
    repeat (20) @(negedge clk);
    phi2 = 1'b0;
    @(negedge clk);
    ncs = 1'b1; nwe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr = a; nwe = 1'b1; ncs = 1'b0; phi2 = 1'b1;
    repeat (8) @(negedge clk);
    d  = data_out;
    oe = data_oe;
    phi2 = 1'b0;
    @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    exp_q.push_back(exp);
    bus_read(a, d, oe);
    check(tag, d, exp_q.pop_front());
    check({tag, "_oe"}, {7'b0, oe}, 8'h01);
  endtask

  initial begin
    int t0;
    int r0;
    int f0;
    reset = 1'b1; phi2 = 1'b0; ncs = 1'b1; nwe = 1'b1; addr = 2'd0; data_in = 8'h00;
    tx_full = 1'b0; tx_empty = 1'b1; rx_out = 8'h3C; rx_full = 1'b0; rx_empty = 1'b1;
    rx_write_trig = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data_oe", {7'b0, data_oe}, 8'h00);
    check("rst_irq_n", {7'b0, irq_n}, 8'h01);
    check("rst_data_out", data_out, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    read_expect("rst_ctrl", 2'd2, 8'h00);

    // TX push: exactly one trigger per bus cycle, carrying the bus data.
    t0 = trig_cnt;
    bus_write(2'd0, 8'hA5);
    check("tx_trig_cnt", 8'(trig_cnt - t0), 8'h01);
    check("tx_trig_data", trig_data, 8'hA5);

    // RX pop.
    rx_empty = 1'b0;
    r0 = rra_rise;
    read_expect("rx_data", 2'd0, 8'h3C);
    check("rx_rise_cnt", 8'(rra_rise - r0), 8'h01);
    check("rx_end_oe", {7'b0, data_oe}, 8'h00);
    check("rx_end_data", data_out, 8'h00);
    check("rx_end_active", {7'b0, rx_read_active}, 8'h00);
    rx_empty = 1'b1;

    // TX overrun, cleared by the STATUS read.
    tx_full = 1'b1;
    bus_write(2'd0, 8'h11);
    check("txovr_irq", {7'b0, irq_n}, 8'h00);
    read_expect("status_txovr", 2'd1, 8'h04);
    read_expect("status_clr", 2'd1, 8'h00);

    // RX overrun.
    rx_full = 1'b1;
    @(negedge clk); rx_write_trig = 1'b1;
    @(negedge clk); rx_write_trig = 1'b0; rx_full = 1'b0;
    read_expect("status_rxovr", 2'd1, 8'h08);
    read_expect("status_clr2", 2'd1, 8'h00);
    tx_full = 1'b0;
    repeat (2) @(negedge clk);
    check("ovr_clr_irq", {7'b0, irq_n}, 8'h01);

    // STATUS is read-only; SCRATCH round-trips.
    bus_write(2'd1, 8'hFF);
    read_expect("status_ro", 2'd1, 8'h01);
    bus_write(2'd3, 8'h5A);
    read_expect("scratch", 2'd3, 8'h5A);

    // CTRL with flush bit.
    f0 = flush_cnt;
    bus_write(2'd2, 8'h81);
    check("flush_pulse", 8'(flush_cnt - f0), 8'h01);
    read_expect("ctrl_rd", 2'd2, 8'h01);
    check("irq_idle", {7'b0, irq_n}, 8'h01);
    rx_empty = 1'b0;
    @(negedge clk);
    check("irq_rx", {7'b0, irq_n}, 8'h00);
    read_expect("ctrl_rd2", 2'd2, 8'h01);

    // Reset in the middle of a DATA read.
    @(negedge clk);
    addr = 2'd0; nwe = 1'b1; ncs = 1'b0; phi2 = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_active", {7'b0, rx_read_active}, 8'h01);
    check("mid_oe", {7'b0, data_oe}, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_active", {7'b0, rx_read_active}, 8'h00);
    check("rst_mid_oe", {7'b0, data_oe}, 8'h00);
    reset = 1'b0;
    r0 = rra_rise;
    repeat (10) @(negedge clk);
    check("no_reaccess_cnt", 8'(rra_rise - r0), 8'h00);
    check("no_reaccess_oe", {7'b0, data_oe}, 8'h00);
    phi2 = 1'b0;
    repeat (4) @(negedge clk);
    phi2 = 1'b1;
    repeat (6) @(negedge clk);
    check("new_access_oe", {7'b0, data_oe}, 8'h01);
    check("new_access_cnt", 8'(rra_rise - r0), 8'h01);
    phi2 = 1'b0;
    @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
    check("final_oe", {7'b0, data_oe}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
